spi_master_ctrl: RTL

//   SPI master transfer engine. Drives the shift-register stage with load, shift and

---
 rtl/spi_master_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI mode 0 (CPOL=0, CPHA=0), MSB-first master transfer engine.
// Accepts one NBITS word on a val/rdy request port, shifts it out on MOSI while
// capturing MISO, and returns the received word on a val/rdy response port.
// Optional feature macro: SPI_MASTER_LOOPBACK_EN adds a 'loopback' input. When it
// is latched high at accept, MOSI is sampled instead of MISO.
module spi_master_ctrl #(
    parameter int NBITS   = 8,
    parameter int NCS     = 1,
    parameter int CLK_DIV = 2,
    localparam int CSW    = (NCS > 1) ? $clog2(NCS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             send_val,
    output logic             send_rdy,
    input  logic [NBITS-1:0] send_msg,
    input  logic [CSW-1:0]   send_cs,
`ifdef SPI_MASTER_LOOPBACK_EN
    input  logic             loopback,
`endif
    output logic             recv_val,
    input  logic             recv_rdy,
    output logic [NBITS-1:0] recv_msg,
    output logic             spi_sclk,
    output logic [NCS-1:0]   spi_cs,
    output logic             spi_mosi,
    input  logic             spi_miso
);

    localparam int DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNTW = $clog2(NBITS + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [DIVW-1:0]   div_reg;
    logic [CNTW-1:0]   bit_cnt_reg;
    logic [NBITS-1:0]  sr_reg;
    logic [NBITS-1:0]  sr_next;
    logic              miso_cap_reg;
    logic              sample;
    logic              accept;
    logic              half_done;
    logic              last_bit;
    logic [NCS-1:0]    cs_sel;

    assign accept    = (state_reg == IDLE) && send_val;
    assign half_done = (div_reg == DIVW'(CLK_DIV - 1));
    assign last_bit  = (bit_cnt_reg == CNTW'(NBITS - 1));

    // Active-low one-hot select; an out-of-range index leaves every line high.
    generate
        for (genvar gi = 0; gi < NCS; gi++) begin : g_cs_dec
            assign cs_sel[gi] = (send_cs != CSW'(gi));
        end
    endgenerate

`ifdef SPI_MASTER_LOOPBACK_EN
    logic lb_reg;
    assign sample = lb_reg ? spi_mosi : spi_miso;

    // Loopback selection is fixed for the whole transfer once accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lb_reg <= 1'b0;
        end else if (accept) begin
            lb_reg <= loopback;
        end
    end
`else
    assign sample = spi_miso;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode: each SCLK phase lasts CLK_DIV clk cycles.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (send_val)  state_next = START;
            START: if (half_done) state_next = HIGH;
            HIGH:  if (half_done) state_next = last_bit ? DONE : LOW;
            LOW:   if (half_done) state_next = HIGH;
            DONE:  if (recv_rdy)  state_next = IDLE;
            default:              state_next = IDLE;
        endcase
    end

    // Handshake outputs decode straight from the state; ready is held off during reset.
    always_comb begin
        send_rdy = (state_reg == IDLE) && !reset;
        recv_val = (state_reg == DONE);
    end

    // Shift register next value: load at accept, shift in the captured bit when SCLK falls.
    always_comb begin
        sr_next = sr_reg;
        if (accept) begin
            sr_next = send_msg;
        end else if (state_reg == HIGH && half_done) begin
            sr_next = {sr_reg[NBITS-2:0], miso_cap_reg};
        end
    end

    // Half-period counter restarts on every state change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_reg <= '0;
        end else if (state_next != state_reg) begin
            div_reg <= '0;
        end else if (state_reg == START || state_reg == HIGH || state_reg == LOW) begin
            div_reg <= div_reg + DIVW'(1);
        end
    end

    // Datapath and registered SPI pins; MOSI always changes while SCLK is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_reg       <= '0;
            bit_cnt_reg  <= '0;
            miso_cap_reg <= 1'b0;
            spi_sclk     <= 1'b0;
            spi_cs       <= '1;
            spi_mosi     <= 1'b0;
            recv_msg     <= '0;
        end else begin
            sr_reg <= sr_next;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        bit_cnt_reg <= '0;
                        spi_cs      <= cs_sel;
                        spi_sclk    <= 1'b0;
                        spi_mosi    <= sr_next[NBITS-1];
                    end
                end
                START, LOW: begin
                    if (half_done) begin
                        spi_sclk     <= 1'b1;
                        miso_cap_reg <= sample;
                    end
                end
                HIGH: begin
                    if (half_done) begin
                        bit_cnt_reg <= bit_cnt_reg + CNTW'(1);
                        spi_sclk    <= 1'b0;
                        if (last_bit) begin
                            spi_cs   <= '1;
                            recv_msg <= sr_next;
                        end else begin
                            spi_mosi <= sr_next[NBITS-1];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
